// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port: round-robin between the ALU (A) and the
// load unit (B), with a busy scoreboard of claimed destinations driving the read-side stall.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            claim_v,
  input  logic [AW-1:0]   claim_reg,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_reg,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_reg,
  input  logic [DW-1:0]   b_data,
  output logic            b_ready,
  input  logic [AW-1:0]   rreg1,
  input  logic [AW-1:0]   rreg2,
  output logic            stall,
  output logic            regwr,
  output logic [AW-1:0]   wreg,
  output logic [DW-1:0]   wdata,
  output logic [NREG-1:0] busy
);

  // state  | meaning
  // PRI_A  | A wins a tie (B was granted last, or nothing since reset)
  // PRI_B  | B wins a tie (A was granted last)
  typedef enum logic {PRI_A, PRI_B} pri_t;

  pri_t            r_pri;
  pri_t            w_pri_nxt;
  logic            w_a_gnt;
  logic            w_b_gnt;
  logic            w_xfer;
  logic [AW-1:0]   w_xreg;
  logic [DW-1:0]   w_xdata;
  logic            w_wr_nxt;
  logic [NREG-1:0] w_busy_nxt;

  logic            r_regwr;
  logic [AW-1:0]   r_wreg;
  logic [DW-1:0]   r_wdata;
  logic [NREG-1:0] r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pri <= PRI_A;
    else     r_pri <= w_pri_nxt;
  end

  always_comb begin
    w_a_gnt   = 1'b0;
    w_b_gnt   = 1'b0;
    w_pri_nxt = r_pri;
    if (a_valid && (!b_valid || r_pri == PRI_A)) w_a_gnt = 1'b1;
    else if (b_valid)                            w_b_gnt = 1'b1;
    if (w_a_gnt)      w_pri_nxt = PRI_B;
    else if (w_b_gnt) w_pri_nxt = PRI_A;
  end

  assign w_xfer   = w_a_gnt | w_b_gnt;
  assign w_xreg   = w_a_gnt ? a_reg  : b_reg;
  assign w_xdata  = w_a_gnt ? a_data : b_data;
  // Writes to r0 are accepted from the requester but never reach the register file.
  assign w_wr_nxt = w_xfer && (w_xreg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwr <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_regwr <= w_wr_nxt;
      if (w_wr_nxt) begin
        r_wreg  <= w_xreg;
        r_wdata <= w_xdata;
      end
    end
  end

  // Clear before set so a same-edge reclaim keeps the register pending for the new producer.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_regwr) w_busy_nxt[r_wreg] = 1'b0;
    if (claim_v && claim_reg != '0) w_busy_nxt[claim_reg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign a_ready = w_a_gnt;
  assign b_ready = w_b_gnt;
  assign stall   = r_busy[rreg1] | r_busy[rreg2];
  assign regwr   = r_regwr;
  assign wreg    = r_wreg;
  assign wdata   = r_wdata;
  assign busy    = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a directed vector table, hand-written corner sequences, and a
// randomized run compared against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        claim_v = 1'b0;
  logic [4:0]  claim_reg = '0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_reg = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_reg = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic [4:0]  rreg1 = '0;
  logic [4:0]  rreg2 = '0;
  logic        stall;
  logic        regwr;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [31:0] busy;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.NREG(32), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .claim_v(claim_v), .claim_reg(claim_reg),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .rreg1(rreg1), .rreg2(rreg2), .stall(stall),
    .regwr(regwr), .wreg(wreg), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;  logic [4:0] cr;
    logic        av;  logic [4:0] ar; logic [31:0] ad;
    logic        bv;  logic [4:0] br; logic [31:0] bd;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        ea;  logic eb; logic es; logic ew;
    logic [4:0]  ewr; logic [31:0] ewd; logic [31:0] ebusy;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic cv, logic [4:0] cr, logic av, logic [4:0] ar, logic [31:0] ad,
                              logic bv, logic [4:0] br, logic [31:0] bd, logic [4:0] r1,
                              logic [4:0] r2, logic ea, logic eb, logic es, logic ew,
                              logic [4:0] ewr, logic [31:0] ewd, logic [31:0] ebusy);
    vec_t v;
    v.cv = cv; v.cr = cr; v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.r1 = r1; v.r2 = r2; v.ea = ea; v.eb = eb; v.es = es; v.ew = ew; v.ewr = ewr;
    v.ewd = ewd; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    claim_v = 1'b0; claim_reg = '0;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    rreg1 = '0; rreg2 = '0;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Behavioural model state for the random phase.
  bit          m_busy[32];
  bit          m_wr;
  int          m_wreg;
  logic [31:0] m_wdata;
  bit          m_b_last;

  initial begin
    // ---------------- reset values ----------------
    idle_inputs();
    #1;
    chk("reset regwr", {31'd0, regwr}, 32'd0);
    chk("reset wreg", {27'd0, wreg}, 32'd0);
    chk("reset wdata", wdata, 32'd0);
    chk("reset busy", busy, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);

    // ---------------- directed table ----------------
    tbl[0]  = mk(1,20, 0,0,0,          0,0,0,          20,0, 0,0,0,0, 0,32'h0,      32'h0);
    tbl[1]  = mk(0,0,  1,20,32'hF,     0,0,0,          20,0, 1,0,1,0, 0,32'h0,      32'h1 << 20);
    tbl[2]  = mk(0,0,  0,0,0,          0,0,0,          20,0, 0,0,1,1, 20,32'hF,     32'h1 << 20);
    tbl[3]  = mk(0,0,  0,0,0,          0,0,0,          20,0, 0,0,0,0, 20,32'hF,     32'h0);
    tbl[4]  = mk(0,0,  1,3,32'hF0000,  1,4,32'h11,     0,0,  0,1,0,0, 20,32'hF,     32'h0);
    tbl[5]  = mk(0,0,  1,3,32'hF0000,  0,0,0,          0,0,  1,0,0,1, 4,32'h11,     32'h0);
    tbl[6]  = mk(1,0,  0,0,0,          1,0,32'hFFFFFFFF,0,0, 0,1,0,1, 3,32'hF0000,  32'h0);
    tbl[7]  = mk(1,5,  0,0,0,          0,0,0,          0,0,  0,0,0,0, 3,32'hF0000,  32'h0);
    tbl[8]  = mk(0,0,  1,5,32'h55,     0,0,0,          0,5,  1,0,1,0, 3,32'hF0000,  32'h1 << 5);
    tbl[9]  = mk(1,5,  0,0,0,          0,0,0,          0,5,  0,0,1,1, 5,32'h55,     32'h1 << 5);
    tbl[10] = mk(0,0,  0,0,0,          0,0,0,          0,5,  0,0,1,0, 5,32'h55,     32'h1 << 5);
    tbl[11] = mk(0,0,  1,5,32'h66,     0,0,0,          0,5,  1,0,1,0, 5,32'h55,     32'h1 << 5);
    tbl[12] = mk(0,0,  0,0,0,          0,0,0,          0,5,  0,0,1,1, 5,32'h66,     32'h1 << 5);
    tbl[13] = mk(0,0,  0,0,0,          0,0,0,          0,5,  0,0,0,0, 5,32'h66,     32'h0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      claim_v = tbl[i].cv; claim_reg = tbl[i].cr;
      a_valid = tbl[i].av; a_reg = tbl[i].ar; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_reg = tbl[i].br; b_data = tbl[i].bd;
      rreg1 = tbl[i].r1; rreg2 = tbl[i].r2;
      @(negedge clk);
      chk($sformatf("row%0d a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].ea});
      chk($sformatf("row%0d b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].eb});
      chk($sformatf("row%0d stall", i),   {31'd0, stall},   {31'd0, tbl[i].es});
      chk($sformatf("row%0d regwr", i),   {31'd0, regwr},   {31'd0, tbl[i].ew});
      chk($sformatf("row%0d wreg", i),    {27'd0, wreg},    {27'd0, tbl[i].ewr});
      chk($sformatf("row%0d wdata", i),   wdata,            tbl[i].ewd);
      chk($sformatf("row%0d busy", i),    busy,             tbl[i].ebusy);
      @(posedge clk);
      #1;
    end

    // ---------------- contention straight from reset ----------------
    do_reset();
    a_valid = 1; a_reg = 3; a_data = 32'h000F0000;
    b_valid = 1; b_reg = 4; b_data = 32'h11;
    @(negedge clk);
    chk("cont first a_ready", {31'd0, a_ready}, 32'd1);
    chk("cont first b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk);
    chk("cont second b_ready", {31'd0, b_ready}, 32'd1);
    chk("cont wr1 regwr", {31'd0, regwr}, 32'd1);
    chk("cont wr1 wreg", {27'd0, wreg}, 32'd3);
    chk("cont wr1 wdata", wdata, 32'h000F0000);
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    chk("cont wr2 regwr", {31'd0, regwr}, 32'd1);
    chk("cont wr2 wreg", {27'd0, wreg}, 32'd4);
    chk("cont wr2 wdata", wdata, 32'h11);

    // ---------------- fairness over six contended cycles ----------------
    do_reset();
    a_valid = 1; a_reg = 1; a_data = 32'hA;
    b_valid = 1; b_reg = 2; b_data = 32'hB;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fair%0d a_ready", i), {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("fair%0d b_ready", i), {31'd0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("fair%0d wreg", i), {27'd0, wreg}, (i % 2 == 1) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
    end
    idle_inputs();

    // ---------------- reset with a write pending ----------------
    do_reset();
    claim_v = 1; claim_reg = 7;
    @(posedge clk); #1;
    claim_v = 0;
    a_valid = 1; a_reg = 7; a_data = 32'h77; rreg1 = 7;
    @(negedge clk);
    chk("rstmid stall before", {31'd0, stall}, 32'd1);
    chk("rstmid a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk); #1;
    a_valid = 0;
    chk("rstmid regwr pending", {31'd0, regwr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid regwr", {31'd0, regwr}, 32'd0);
    chk("rstmid busy", busy, 32'd0);
    chk("rstmid stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid after regwr", {31'd0, regwr}, 32'd0);
    chk("rstmid after wreg", {27'd0, wreg}, 32'd0);
    chk("rstmid after busy", busy, 32'd0);

    // ---------------- randomized run against the model ----------------
    @(posedge clk); #1;
    do_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    m_wr = 0; m_wreg = 0; m_wdata = '0; m_b_last = 1;
    begin
      bit a_hold = 0;
      bit b_hold = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        bit ea, eb, es;
        logic [31:0] eb_vec;
        bit n_wr;
        int n_reg;
        logic [31:0] n_data;
        claim_v = ($urandom_range(0, 2) == 0);
        claim_reg = 5'($urandom_range(0, 31));
        if (!a_hold) begin
          a_valid = ($urandom_range(0, 1) == 1);
          a_reg = 5'($urandom_range(0, 31));
          a_data = $urandom;
        end
        if (!b_hold) begin
          b_valid = ($urandom_range(0, 1) == 1);
          b_reg = 5'($urandom_range(0, 31));
          b_data = $urandom;
        end
        rreg1 = 5'($urandom_range(0, 31));
        rreg2 = 5'($urandom_range(0, 31));
        @(negedge clk);
        // A alone, or a tie where B was served last, goes to A; otherwise B if it asks.
        ea = a_valid && (!b_valid || m_b_last);
        eb = b_valid && !ea;
        es = m_busy[rreg1] || m_busy[rreg2];
        eb_vec = '0;
        for (int r = 0; r < 32; r++) eb_vec[r] = m_busy[r];
        chk($sformatf("rnd%0d a_ready", cyc), {31'd0, a_ready}, {31'd0, ea});
        chk($sformatf("rnd%0d b_ready", cyc), {31'd0, b_ready}, {31'd0, eb});
        chk($sformatf("rnd%0d stall", cyc), {31'd0, stall}, {31'd0, es});
        chk($sformatf("rnd%0d regwr", cyc), {31'd0, regwr}, {31'd0, m_wr});
        chk($sformatf("rnd%0d wreg", cyc), {27'd0, wreg}, 32'(m_wreg));
        chk($sformatf("rnd%0d wdata", cyc), wdata, m_wdata);
        chk($sformatf("rnd%0d busy", cyc), busy, eb_vec);
        n_wr = 0; n_reg = m_wreg; n_data = m_wdata;
        if (ea) begin
          m_b_last = 0;
          if (a_reg != 0) begin n_wr = 1; n_reg = a_reg; n_data = a_data; end
        end else if (eb) begin
          m_b_last = 1;
          if (b_reg != 0) begin n_wr = 1; n_reg = b_reg; n_data = b_data; end
        end
        if (m_wr) m_busy[m_wreg] = 0;
        if (claim_v && claim_reg != 0) m_busy[claim_reg] = 1;
        m_wr = n_wr; m_wreg = n_reg; m_wdata = n_data;
        a_hold = a_valid && !ea;
        b_hold = b_valid && !eb;
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
